// File: rtl/ping_sequencer.sv
// Ping cycle sequencer: TX burst, guard blanking, listen window with first-echo time-of-flight, holdoff.
// Optional build macro PING_AUTO_REPEAT_EN adds the auto_en port for back-to-back pings.
module ping_sequencer #(
    parameter int BURST_LEN   = 512,
    parameter int GUARD_LEN   = 64,
    parameter int LISTEN_LEN  = 1024,
    parameter int HOLDOFF_LEN = 1024,
    parameter int TOFW        = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trig_stb,
    input  logic            echo_in,
`ifdef PING_AUTO_REPEAT_EN
    input  logic            auto_en,
`endif
    output logic            tx_en,
    output logic            capture_en,
    output logic            busy,
    output logic [TOFW-1:0] tof,
    output logic            tof_stb,
    output logic            timeout,
    output logic [7:0]      ping_cnt
);

    localparam int MAX_BG  = (BURST_LEN > GUARD_LEN) ? BURST_LEN : GUARD_LEN;
    localparam int MAX_LH  = (LISTEN_LEN > HOLDOFF_LEN) ? LISTEN_LEN : HOLDOFF_LEN;
    localparam int MAX_LEN = (MAX_BG > MAX_LH) ? MAX_BG : MAX_LH;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] BURST_LAST   = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_LEN - 1);
    localparam logic [CW-1:0] LISTEN_LAST  = CW'(LISTEN_LEN - 1);
    localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_BURST = 3'd1,
        S_GUARD    = 3'd2,
        S_LISTEN   = 3'd3,
        S_HOLDOFF  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          echo_q_r;
    logic          edge_s;
    logic          start_s;
    logic          stb_s;
    logic          to_s;
    logic          auto_s;

`ifdef PING_AUTO_REPEAT_EN
    assign auto_s = auto_en;
`else
    assign auto_s = 1'b0;
`endif

    // A fresh rise is required: echo already high when the window opens is ignored.
    assign edge_s = echo_in & ~echo_q_r;

    // Next-state and shared duration counter; in LISTEN the counter is the listen index.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_s     = 1'b0;
        stb_s       = 1'b0;
        to_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (trig_stb) begin
                    state_nxt_s = S_TX_BURST;
                    cnt_nxt_s   = '0;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_TX_BURST: begin
                if (cnt_r == BURST_LAST) begin
                    state_nxt_s = S_GUARD;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            S_GUARD: begin
                if (cnt_r == GUARD_LAST) begin
                    state_nxt_s = S_LISTEN;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            S_LISTEN: begin
                // An edge on the last index wins over the timeout.
                if (edge_s) begin
                    state_nxt_s = S_HOLDOFF;
                    cnt_nxt_s   = '0;
                    stb_s       = 1'b1;
                end else if (cnt_r == LISTEN_LAST) begin
                    state_nxt_s = S_HOLDOFF;
                    cnt_nxt_s   = '0;
                    to_s        = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            S_HOLDOFF: begin
                if (cnt_r == HOLDOFF_LAST) begin
                    cnt_nxt_s = '0;
                    if (auto_s) begin
                        state_nxt_s = S_TX_BURST;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter, echo history and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            echo_q_r   <= 1'b0;
            tx_en      <= 1'b0;
            capture_en <= 1'b0;
            busy       <= 1'b0;
            tof        <= '0;
            tof_stb    <= 1'b0;
            timeout    <= 1'b0;
            ping_cnt   <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            echo_q_r   <= echo_in;
            tx_en      <= (state_nxt_s == S_TX_BURST);
            capture_en <= (state_nxt_s == S_LISTEN);
            busy       <= (state_nxt_s != S_IDLE);
            tof_stb    <= stb_s;
            timeout    <= to_s;
            if (stb_s) begin
                tof <= TOFW'(cnt_r);
            end
            if (start_s) begin
                ping_cnt <= ping_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ping_sequencer.sv
// Bench for ping_sequencer: directed scenarios plus random triggers/echoes against a timestamp model.
// Build with PING_AUTO_REPEAT_EN defined to also exercise auto_en.
module tb_ping_sequencer;

    localparam int B  = 8;
    localparam int G  = 4;
    localparam int L  = 16;
    localparam int H  = 4;
    localparam int TW = 5;

    logic          clk;
    logic          rst;
    logic          trig_stb;
    logic          echo_in;
    logic          auto_en;
    logic          tx_en;
    logic          capture_en;
    logic          busy;
    logic [TW-1:0] tof;
    logic          tof_stb;
    logic          timeout;
    logic [7:0]    ping_cnt;

    int n_checks;
    int n_errors;

    // Timestamp model: a ping is described by its start edge and the edge where listening ended.
    int n_edge;
    bit m_in;
    bit m_done;
    int m_start;
    int m_hs;
    int m_tof;
    int m_pings;
    bit m_prev;
    bit e_stb;
    bit e_to;
    bit e_tx;
    bit e_cap;

    ping_sequencer #(
        .BURST_LEN(B), .GUARD_LEN(G), .LISTEN_LEN(L), .HOLDOFF_LEN(H), .TOFW(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trig_stb(trig_stb),
        .echo_in(echo_in),
`ifdef PING_AUTO_REPEAT_EN
        .auto_en(auto_en),
`endif
        .tx_en(tx_en),
        .capture_en(capture_en),
        .busy(busy),
        .tof(tof),
        .tof_stb(tof_stb),
        .timeout(timeout),
        .ping_cnt(ping_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in    = 1'b0;
        m_done  = 1'b0;
        m_tof   = 0;
        m_pings = 0;
        m_prev  = 1'b0;
        e_stb   = 1'b0;
        e_to    = 1'b0;
    endtask

    task automatic model_edge();
        int k;
        int i;
        int mm;
        e_stb = 1'b0;
        e_to  = 1'b0;
        if (m_in) begin
            k = n_edge - m_start;
            if (!m_done && k >= B + G + 1) begin
                i = k - (B + G + 1);
                if (echo_in && !m_prev) begin
                    m_done = 1'b1; m_hs = n_edge; m_tof = i; e_stb = 1'b1;
                end else if (i == L - 1) begin
                    m_done = 1'b1; m_hs = n_edge; e_to = 1'b1;
                end
            end else if (m_done && n_edge == m_hs + H) begin
                if (auto_en) begin
                    m_start = n_edge; m_done = 1'b0; m_pings = (m_pings + 1) % 256;
                end else begin
                    m_in = 1'b0;
                end
            end
        end else if (trig_stb) begin
            m_in = 1'b1; m_start = n_edge; m_done = 1'b0; m_pings = (m_pings + 1) % 256;
        end
        m_prev = echo_in;
        mm    = n_edge + 1 - m_start;
        e_tx  = m_in && mm >= 1 && mm <= B;
        e_cap = m_in && !m_done && mm >= B + G + 1;
        n_edge++;
    endtask

    task automatic compare_all();
        chk("tx_en", int'(tx_en), int'(e_tx));
        chk("capture_en", int'(capture_en), int'(e_cap));
        chk("busy", int'(busy), int'(m_in));
        chk("tof_stb", int'(tof_stb), int'(e_stb));
        chk("timeout", int'(timeout), int'(e_to));
        chk("tof", int'(tof), m_tof);
        chk("ping_cnt", int'(ping_cnt), m_pings);
    endtask

    task automatic step(input logic t, input logic e, input logic a);
        trig_stb = t;
        echo_in  = e;
        auto_en  = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Assert reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_capture_en", int'(capture_en), 0);
        chk("rst_ping_cnt", int'(ping_cnt), 0);
        chk("rst_tof", int'(tof), 0);
        chk("rst_pulses", int'(tof_stb) + int'(timeout), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic e;
        n_checks = 0;
        n_errors = 0;
        n_edge   = 0;
        rst      = 1'b1;
        trig_stb = 1'b0;
        echo_in  = 1'b0;
        auto_en  = 1'b0;
        model_reset();
        #2;
        do_reset();

        // No echo: full window then timeout.
        for (int r = 0; r < 40; r++) begin
            step(r == 0, 1'b0, 1'b0);
            if (r == 7)  chk("s1_tx_last", int'(tx_en), 1);
            if (r == 8)  chk("s1_tx_off", int'(tx_en), 0);
            if (r == 12) chk("s1_cap_on", int'(capture_en), 1);
            if (r == 28) chk("s1_timeout", int'(timeout), 1);
            if (r == 31) chk("s1_busy_hold", int'(busy), 1);
            if (r == 32) chk("s1_busy_low", int'(busy), 0);
        end
        chk("s1_ping_cnt", int'(ping_cnt), 1);

        // Echo rising at listen index 5.
        for (int r = 0; r < 40; r++) begin
            step(r == 0, r >= 18 && r < 25, 1'b0);
            if (r == 18) begin
                chk("s2_tof_stb", int'(tof_stb), 1);
                chk("s2_tof", int'(tof), 5);
                chk("s2_cap_low", int'(capture_en), 0);
            end
            if (r == 21) chk("s2_busy_hold", int'(busy), 1);
            if (r == 22) chk("s2_busy_low", int'(busy), 0);
        end

        // Trigger while busy is ignored; trigger on first idle cycle is accepted.
        for (int r = 0; r < 70; r++) begin
            step(r == 0 || r == 10 || r == 33, 1'b0, 1'b0);
            if (r == 32) chk("s3_one_ping", int'(ping_cnt), 3);
            if (r == 33) chk("s3_second_ping", int'(ping_cnt), 4);
        end

        // Echo held high across the window opening: timeout, tof kept.
        for (int r = 0; r < 40; r++) begin
            step(r == 0, r >= 10, 1'b0);
            if (r == 28) begin
                chk("s4_timeout", int'(timeout), 1);
                chk("s4_tof_kept", int'(tof), 5);
            end
        end

        // Reset in the middle of the burst, then a clean ping.
        for (int r = 0; r < 5; r++) step(r == 0, 1'b0, 1'b0);
        #3;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            step(r == 0, 1'b0, 1'b0);
            if (r == 0)  chk("s5_ping_cnt", int'(ping_cnt), 1);
            if (r == 28) chk("s5_timeout", int'(timeout), 1);
        end

`ifdef PING_AUTO_REPEAT_EN
        #3;
        do_reset();
        for (int r = 0; r < 75; r++) begin
            step(r == 0, 1'b0, r < 34);
            if (r == 32) begin
                chk("auto_tx_again", int'(tx_en), 1);
                chk("auto_ping_cnt", int'(ping_cnt), 2);
            end
            if (r == 31) chk("auto_busy", int'(busy), 1);
        end
`endif

        // Random triggers, echoes and (when built in) auto repeat.
        e = 1'b0;
        for (int r = 0; r < 900; r++) begin
            if ($urandom_range(5, 0) == 0) e = ~e;
`ifdef PING_AUTO_REPEAT_EN
            step($urandom_range(9, 0) == 0, e, $urandom_range(3, 0) == 0);
`else
            step($urandom_range(9, 0) == 0, e, 1'b0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ping_sequencer.md
# ping_sequencer

Sequences one acoustic/RF ping cycle for the phase-ping front end: gates the PLL carrier onto the TX pad for a fixed burst, blanks the receiver during a guard window, opens a listen window for the digitizer/hex-dump capture path, and measures time-of-flight to the first echo edge. It replaces the ad-hoc counters in the top level and sits between the UART trigger strobe, the TX pad output-enable and the capture-ready echo flag.

## Interface
- `BURST_LEN`, 512: TX burst length, cycles (≥1).
- `GUARD_LEN`, 64: post-burst blanking, cycles (≥1).
- `LISTEN_LEN`, 1024: listen window, cycles (≥1, ≤2^TOFW).
- `HOLDOFF_LEN`, 1024: quiet time before next ping, cycles (≥1).
- `TOFW`, 11: width of time-of-flight result.

- `clk`  in  1  system clock (48 MHz xtal).
- `rst`  in  1  reset, asynchronous, active-high.
- `trig_stb`  in  1  start request, single-cycle pulse.
- `echo_in`  in  1  echo/capture-ready level from detector.
- `tx_en`  out  1  TX pad output enable (PLL carrier gate).
- `capture_en`  out  1  high during listen window.
- `busy`  out  1  high whenever not IDLE.
- `tof`  out  TOFW  listen-cycle index of first echo rising edge.
- `tof_stb`  out  1  one-cycle pulse, `tof` updated.
- `timeout`  out  1  one-cycle pulse, window closed with no echo.
- `ping_cnt`  out  8  pings started, wraps 255→0.
- `auto_en`  in  1  present only with `PING_AUTO_REPEAT_EN`.

## Operation
- States: IDLE → TX_BURST → GUARD → LISTEN → HOLDOFF → IDLE.
- IDLE: `trig_stb`=1 → TX_BURST; `ping_cnt` increments on entry. `trig_stb` in any other state ignored, not queued.
- TX_BURST: `tx_en`=1 for exactly BURST_LEN cycles, then GUARD.
- GUARD: all gates low for GUARD_LEN cycles, then LISTEN.
- LISTEN: `capture_en`=1; index counter i runs 0..LISTEN_LEN-1. Echo edge = `echo_in`=1 with registered previous sample `echo_q`=0; `echo_q` updates every cycle in all states. On edge at index i: `tof`←i, → HOLDOFF, `tof_stb` pulses in first HOLDOFF cycle. If i=LISTEN_LEN-1 passes without edge: `tof` unchanged, → HOLDOFF, `timeout` pulses in first HOLDOFF cycle. Edge on last index counts as echo (never both pulses).
- Echo already high when LISTEN opens is not an edge; a fresh rise is required.
- HOLDOFF: HOLDOFF_LEN cycles, then IDLE.
- One shared down/up counter for state durations, width clog2 of largest length; `tof` captured from it during LISTEN.
- All outputs registered (no combinational paths input→output).

## Timing
- Cycle 0 = cycle with `trig_stb`=1 at its clock edge in IDLE. `tx_en`, `busy` high from cycle 1; `tx_en` cycles 1..BURST_LEN.
- `capture_en` cycles BURST_LEN+GUARD_LEN+1 .. BURST_LEN+GUARD_LEN+LISTEN_LEN; index i occupies cycle BURST_LEN+GUARD_LEN+1+i.
- Echo at index i: `capture_en` drops and `tof_stb` pulses the following cycle; IDLE HOLDOFF_LEN cycles later.
- New trigger accepted the first cycle `busy`=0.
- Reset values (asserted asynchronously, any state): state IDLE, `tx_en`=`capture_en`=`busy`=`tof_stb`=`timeout`=0, `tof`=0, `ping_cnt`=0, `echo_q`=0. Reset mid-burst drops `tx_en` without waiting for a clock.

## Configuration
- `PING_AUTO_REPEAT_EN` defined: `auto_en` port exists; if `auto_en`=1 in the last HOLDOFF cycle, next cycle enters TX_BURST directly (`ping_cnt` increments, `busy` stays high). `auto_en`=0 → IDLE as normal.
- Undefined: no `auto_en` port; every ping needs `trig_stb` from IDLE.

## Test plan
Params BURST_LEN=8, GUARD_LEN=4, LISTEN_LEN=16, HOLDOFF_LEN=4.
- Trig cycle 0, `echo_in`=0 → `tx_en` cycles 1–8, `capture_en` 13–28, `timeout` at 29, `busy` low at 33, `ping_cnt`=1, no `tof_stb`.
- Trig cycle 0, `echo_in` rises cycle 18 → `tof`=5, `tof_stb` at 19, `capture_en` low at 19, `busy` low at 23.
- Trig pulses at cycles 0 and 10 → single ping, `ping_cnt`=1; trig at 33 → second ping, `ping_cnt`=2.
- `echo_in` high from cycle 10 onward → no edge in LISTEN, `timeout` at 29, `tof` unchanged.
- `rst` high mid-cycle 5 → `tx_en`, `busy` low immediately, `ping_cnt`=0; trig after release → normal ping from its cycle 0.
- With `PING_AUTO_REPEAT_EN`, `auto_en`=1, single trig at 0 → second `tx_en` burst cycles 33–40, `busy` continuously high, `ping_cnt`=2 at 33.
